uart_baud_gen: RTL
==================

Name: uart_baud_gen

Overview:
- Next-generation UART rate generator.
- Replaces the fixed divide-by-25 clock output with a runtime-programmable fractional divisor.
- Produces single-cycle clock-enable strobes rather than a derived clock: an oversample tick (os_tick) and a bit tick (bit_tick).
- Feeds the UART TX/RX datapaths, which run on clk_in and qualify their logic with these strobes.

Parameters:
- DIV_W, 16: width of the integer divisor.
- FRAC_W, 4: width of the fractional divisor, in units of 1/2^FRAC_W.
- OSR, 16: oversample ticks per bit; must be a power of two, at least 2.
- DEF_INT, 27: integer divisor after reset (50 MHz, 115200 baud, 16x).
- DEF_FRAC, 2: fractional divisor after reset (2/16, giving 27.125).

Ports:
- clk_in  in  1  system clock.
- rst  in  1  synchronous reset, active-high.
- en  in  1  run enable; low means hold and restart.
- cfg_div_int  in  DIV_W  requested integer divisor.
- cfg_div_frac  in  FRAC_W  requested fractional divisor.
- cfg_wr  in  1  one-cycle request to load cfg_div_int/cfg_div_frac.
- cfg_ack  out  1  one-cycle pulse in the cycle the new divisor takes effect.
- cfg_pend  out  1  high while a written divisor waits to be applied.
- os_tick  out  1  oversample strobe.
- bit_tick  out  1  bit strobe, coincident with every OSR-th os_tick.
- os_phase  out  $clog2(OSR)  index of the current oversample within the bit.

Behaviour:
- Clocking and reset: one clock, clk_in; rst is synchronous and active-high.
- Reset values:
  - Active divisor = DEF_INT/DEF_FRAC; shadow = same.
  - cnt = DEF_INT-1; acc = 0; os_phase = 0; cfg_pend = 0.
  - os_tick = bit_tick = cfg_ack = 0.
- Divisor clamp: an active integer divisor of 0 is treated as 1. Length of one os interval is always ≥1.
- Strobe decode: os_tick = en && (cnt == 0), decoded from registers (no input-to-output path except en). bit_tick = os_tick && (os_phase == OSR-1).
- Counter step when en=1 and cnt≠0: cnt decrements.
- Counter step on an os_tick:
  - {c, acc_n} = acc + frac, computed FRAC_W+1 wide.
  - acc <= acc_n.
  - cnt <= int - 1 + c.
  - os_phase <= os_phase + 1, wrapping at OSR.
- Interval length: each os interval lasts int + c cycles, so the long-run average is int + frac/2^FRAC_W. The error does not accumulate.
- Disable (en=0), every cycle:
  - cnt <= int-1, acc <= 0, os_phase <= 0.
  - No strobes are asserted.
- Re-enable: after en rises, the first os_tick occurs in the int-th cycle with en=1. This gives a deterministic restart that RX uses for start-bit alignment.
- Config write (cfg_wr=1): the shadow captures cfg_div_int/cfg_div_frac and cfg_pend is set.
  - Repeated writes while pending overwrite the shadow; last wins, and one ack is given.
- Config apply: occurs in the first cycle where cfg_pend=1 and either bit_tick=1 or en=0. A bit never runs with mixed divisors. In that cycle:
  - active <= shadow; cnt <= new int-1; acc <= 0; os_phase <= 0.
  - cfg_pend <= 0; cfg_ack = 1 for that one cycle.
- Config same-cycle collision: a cfg_wr in the same cycle as an apply is captured into the shadow and leaves cfg_pend=1. The older pending value is the one applied.
- Reset mid-operation: all state returns to reset values; a pending config is discarded with no ack.

Decomposition:
- Package uart_pkg holds:
  - DEF_INT and DEF_FRAC constants;
  - OSR_DEFAULT;
  - typedefs div_int_t and div_frac_t (logic [DIV_W-1:0] and logic [FRAC_W-1:0] at package defaults).
- One natural sub-module, uart_frac_prescaler:
  - contains cnt, acc and carry logic;
  - takes en, int, frac and a load strobe;
  - emits os_tick.
- The top level keeps the phase counter, the shadow/pending logic and the ack.

Test Plan:
- Reset then en=1 with defaults (27 + 2/16): os intervals follow a 27-cycle pattern with one 28-cycle interval in every 8. 128 os intervals total 3472 cycles exactly. bit_tick occurs every 16 os_ticks.
- cfg int=4, frac=0, applied with en=0, then en=1: os_tick on cycles 4, 8, 12, …; bit_tick every 64 cycles. os_phase counts 0..15 and wraps.
- int=4, frac=4: interval lengths repeat 4,4,4,5. bit_tick period is 68 cycles.
- Write int=8 mid-bit with en=1: cfg_pend stays high until the next bit_tick. cfg_ack pulses in that bit_tick cycle. The next interval is 8 cycles and os_phase restarts at 0. Two writes before the apply give one ack, and the second value is used.
- int=0, frac=0: os_tick every cycle. int=1, frac=8: intervals alternate 1,2.
- rst asserted with a write pending and en=1: no ack; the next interval uses the defaults. Dropping en for 1 cycle then raising it gives the first os_tick int cycles later with os_phase=0.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared constants and divisor types for the UART rate generator.
package uart_pkg;

   localparam int unsigned DIV_W_DEFAULT  = 16;
   localparam int unsigned FRAC_W_DEFAULT = 4;
   localparam int unsigned OSR_DEFAULT    = 16;
   localparam int unsigned DEF_INT        = 27;
   localparam int unsigned DEF_FRAC       = 2;

   typedef logic [DIV_W_DEFAULT-1:0]  div_int_t;
   typedef logic [FRAC_W_DEFAULT-1:0] div_frac_t;

endpackage

// File: rtl/uart_frac_prescaler.sv
// Fractional prescaler: counts div_int (+1 on accumulator carry) cycles per os_tick.
module uart_frac_prescaler #(
   parameter int unsigned DIV_W   = 16,
   parameter int unsigned FRAC_W  = 4,
   parameter int unsigned RST_CNT = 26
) (
   input  logic              clk_in,
   input  logic              rst,
   input  logic              en,
   input  logic              load,
   input  logic [DIV_W-1:0]  div_int,
   input  logic [FRAC_W-1:0] div_frac,
   output logic              os_tick
);

   logic [DIV_W-1:0]  cnt;
   logic [DIV_W-1:0]  cnt_nxt;
   logic [FRAC_W-1:0] acc;
   logic [FRAC_W-1:0] acc_nxt;
   logic [FRAC_W:0]   sum;

   assign os_tick = en && (cnt == '0);

   // div_int is already clamped to >= 1 by the caller, so div_int-1 never wraps
   always_comb begin
      sum     = {1'b0, acc} + {1'b0, div_frac};
      cnt_nxt = cnt;
      acc_nxt = acc;
      if (load || !en) begin
         cnt_nxt = div_int - DIV_W'(1);
         acc_nxt = '0;
      end else if (os_tick) begin
         cnt_nxt = div_int - DIV_W'(1) + DIV_W'(sum[FRAC_W]);
         acc_nxt = sum[FRAC_W-1:0];
      end else begin
         cnt_nxt = cnt - DIV_W'(1);
      end
   end

   always_ff @(posedge clk_in) begin
      if (rst) begin
         cnt <= DIV_W'(RST_CNT);
         acc <= '0;
      end else begin
         cnt <= cnt_nxt;
         acc <= acc_nxt;
      end
   end

endmodule

// File: rtl/uart_baud_gen.sv
// UART rate generator: programmable fractional divisor producing os_tick/bit_tick strobes.
module uart_baud_gen #(
   parameter int unsigned DIV_W    = uart_pkg::DIV_W_DEFAULT,
   parameter int unsigned FRAC_W   = uart_pkg::FRAC_W_DEFAULT,
   parameter int unsigned OSR      = uart_pkg::OSR_DEFAULT,
   parameter int unsigned DEF_INT  = uart_pkg::DEF_INT,
   parameter int unsigned DEF_FRAC = uart_pkg::DEF_FRAC
) (
   input  logic                    clk_in,
   input  logic                    rst,
   input  logic                    en,
   input  logic [DIV_W-1:0]        cfg_div_int,
   input  logic [FRAC_W-1:0]       cfg_div_frac,
   input  logic                    cfg_wr,
   output logic                    cfg_ack,
   output logic                    cfg_pend,
   output logic                    os_tick,
   output logic                    bit_tick,
   output logic [$clog2(OSR)-1:0]  os_phase
);

   localparam int unsigned PH_W    = $clog2(OSR);
   localparam int unsigned RST_CNT = (DEF_INT == 0) ? 0 : DEF_INT - 1;

   logic [DIV_W-1:0]  act_int;
   logic [DIV_W-1:0]  act_int_nxt;
   logic [FRAC_W-1:0] act_frac;
   logic [FRAC_W-1:0] act_frac_nxt;
   logic [DIV_W-1:0]  shd_int;
   logic [DIV_W-1:0]  shd_int_nxt;
   logic [FRAC_W-1:0] shd_frac;
   logic [FRAC_W-1:0] shd_frac_nxt;
   logic              pend_nxt;
   logic [PH_W-1:0]   phase_nxt;
   logic              apply_c;
   logic [DIV_W-1:0]  ld_int;

   assign bit_tick = os_tick && (os_phase == PH_W'(OSR - 1));
   assign cfg_ack  = apply_c && !rst;

   uart_frac_prescaler #(
      .DIV_W   (DIV_W),
      .FRAC_W  (FRAC_W),
      .RST_CNT (RST_CNT)
   ) u_presc (
      .clk_in   (clk_in),
      .rst      (rst),
      .en       (en),
      .load     (apply_c),
      .div_int  (ld_int),
      .div_frac (act_frac),
      .os_tick  (os_tick)
   );

   // Divisor changes only at a bit boundary or while idle, so no bit mixes divisors
   always_comb begin
      apply_c      = cfg_pend && (bit_tick || !en);
      ld_int       = apply_c ? shd_int : act_int;
      if (ld_int == '0) ld_int = DIV_W'(1);
      act_int_nxt  = act_int;
      act_frac_nxt = act_frac;
      shd_int_nxt  = shd_int;
      shd_frac_nxt = shd_frac;
      phase_nxt    = os_phase;
      pend_nxt     = cfg_wr || (cfg_pend && !apply_c);
      if (apply_c) begin
         act_int_nxt  = shd_int;
         act_frac_nxt = shd_frac;
      end
      if (cfg_wr) begin
         shd_int_nxt  = cfg_div_int;
         shd_frac_nxt = cfg_div_frac;
      end
      if (apply_c || !en) begin
         phase_nxt = '0;
      end else if (os_tick) begin
         phase_nxt = os_phase + PH_W'(1);
      end
   end

   always_ff @(posedge clk_in) begin
      if (rst) begin
         act_int  <= DIV_W'(DEF_INT);
         act_frac <= FRAC_W'(DEF_FRAC);
         shd_int  <= DIV_W'(DEF_INT);
         shd_frac <= FRAC_W'(DEF_FRAC);
         cfg_pend <= 1'b0;
         os_phase <= '0;
      end else begin
         act_int  <= act_int_nxt;
         act_frac <= act_frac_nxt;
         shd_int  <= shd_int_nxt;
         shd_frac <= shd_frac_nxt;
         cfg_pend <= pend_nxt;
         os_phase <= phase_nxt;
      end
   end

endmodule
